// File: rtl/wrt_ptr_full_ctrl.sv
// Write-side pointer and full-flag controller for an asynchronous FIFO.
// Keeps the binary write counter and its Gray image, synchronises the
// Gray read pointer into the write clock domain, and derives registered
// full / almost_full / level flags together with a sticky overflow flag.
module wrt_ptr_full_ctrl #(
   parameter int unsigned ADDR_SIZE    = 4,
   parameter int unsigned AFULL_THRESH = 14
) (
   input  logic                 wrt_clk,
   input  logic                 wrt_rst,
   input  logic                 wrt_en,
   input  logic [ADDR_SIZE:0]   rd_ptr,
   output logic [ADDR_SIZE:0]   wrt_ptr,
   output logic [ADDR_SIZE-1:0] wrt_addr,
   output logic                 wrt_accept,
   output logic                 full,
   output logic                 almost_full,
   output logic [ADDR_SIZE:0]   wrt_level,
   output logic                 wrt_ovf
);

   localparam int unsigned PW = ADDR_SIZE + 1;
   localparam logic [ADDR_SIZE:0] AFULL_LVL = PW'(AFULL_THRESH);

   // Read-pointer synchroniser stages
   logic [ADDR_SIZE:0] rq1_q;
   logic [ADDR_SIZE:0] rq2_q;

   // Write counter (binary) and its registered Gray image
   logic [ADDR_SIZE:0] wbin_q;
   logic [ADDR_SIZE:0] wbin_d;
   logic [ADDR_SIZE:0] wgray_q;
   logic [ADDR_SIZE:0] wgray_d;

   // Flag and level state
   logic [ADDR_SIZE:0] level_q;
   logic [ADDR_SIZE:0] level_d;
   logic               full_q;
   logic               full_d;
   logic               afull_q;
   logic               afull_d;
   logic               ovf_q;
   logic               ovf_d;

   // Derived values from the synchronised read pointer
   logic [ADDR_SIZE:0] rbin_sync;
   logic [ADDR_SIZE:0] full_cmp;

   // Accept decision uses the registered full flag; reset blocks all writes
   always_comb begin
      wrt_accept = wrt_en & ~full_q & ~wrt_rst;
   end

   // Next write count and its Gray code
   always_comb begin
      wbin_d  = wbin_q + PW'(wrt_accept);
      wgray_d = (wbin_d >> 1) ^ wbin_d;
   end

   // Gray-to-binary of the synchronised read pointer: bit i is the XOR of
   // all Gray bits from the MSB down to i
   always_comb begin
      rbin_sync = '0;
      for (int unsigned i = 0; i < PW; i++) begin
         rbin_sync[i] = ^(rq2_q >> i);
      end
   end

   // Full pattern: write Gray equals read Gray with the two MSBs inverted
   always_comb begin
      full_cmp = {~rq2_q[ADDR_SIZE:ADDR_SIZE-1], rq2_q[ADDR_SIZE-2:0]};
      full_d   = (wgray_d == full_cmp);
      level_d  = wbin_d - rbin_sync;
      afull_d  = (level_d >= AFULL_LVL);
      ovf_d    = ovf_q | (wrt_en & full_q);
   end

   // Two-flop synchroniser for the read pointer, no logic ahead of rq1
   always_ff @(posedge wrt_clk) begin
      if (wrt_rst) begin
         rq1_q <= '0;
         rq2_q <= '0;
      end else begin
         rq1_q <= rd_ptr;
         rq2_q <= rq1_q;
      end
   end

   // Write pointer registers; unchanged when no write is accepted
   always_ff @(posedge wrt_clk) begin
      if (wrt_rst) begin
         wbin_q  <= '0;
         wgray_q <= '0;
      end else begin
         wbin_q  <= wbin_d;
         wgray_q <= wgray_d;
      end
   end

   // Registered flags and conservative fill level
   always_ff @(posedge wrt_clk) begin
      if (wrt_rst) begin
         full_q  <= 1'b0;
         afull_q <= 1'b0;
         level_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         full_q  <= full_d;
         afull_q <= afull_d;
         level_q <= level_d;
         ovf_q   <= ovf_d;
      end
   end

   assign wrt_ptr     = wgray_q;
   assign wrt_addr    = wbin_q[ADDR_SIZE-1:0];
   assign full        = full_q;
   assign almost_full = afull_q;
   assign wrt_level   = level_q;
   assign wrt_ovf     = ovf_q;

endmodule

// File: tb/tb_wrt_ptr_full_ctrl.sv
// Directed bench for wrt_ptr_full_ctrl (ADDR_SIZE=4, AFULL_THRESH=14).
// Expected values are queued when stimulus is applied and popped when the
// corresponding DUT output is sampled one time unit after the clock edge.
module tb_wrt_ptr_full_ctrl;

   localparam int unsigned AS = 4;

   logic          wrt_clk = 1'b0;
   logic          wrt_rst;
   logic          wrt_en;
   logic [AS:0]   rd_ptr;
   logic [AS:0]   wrt_ptr;
   logic [AS-1:0] wrt_addr;
   logic          wrt_accept;
   logic          full;
   logic          almost_full;
   logic [AS:0]   wrt_level;
   logic          wrt_ovf;

   int            checks = 0;
   int            errors = 0;
   logic [31:0]   sb[$];
   logic [AS:0]   prev_ptr;

   wrt_ptr_full_ctrl #(
      .ADDR_SIZE   (AS),
      .AFULL_THRESH(14)
   ) dut (
      .wrt_clk    (wrt_clk),
      .wrt_rst    (wrt_rst),
      .wrt_en     (wrt_en),
      .rd_ptr     (rd_ptr),
      .wrt_ptr    (wrt_ptr),
      .wrt_addr   (wrt_addr),
      .wrt_accept (wrt_accept),
      .full       (full),
      .almost_full(almost_full),
      .wrt_level  (wrt_level),
      .wrt_ovf    (wrt_ovf)
   );

   always #5 wrt_clk = ~wrt_clk;

   function automatic logic [AS:0] gray(input logic [AS:0] b);
      return b ^ (b >> 1);
   endfunction

   function automatic int unsigned ones(input logic [AS:0] v);
      int unsigned n;
      n = 0;
      for (int k = 0; k <= AS; k++) begin
         if (v[k]) n++;
      end
      return n;
   endfunction

   task automatic push(input logic [31:0] v);
      sb.push_back(v);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs);
      logic [31:0] e;
      checks++;
      if (sb.size() == 0) begin
         errors++;
         $error("FAIL %s observed=%0d expected=<scoreboard empty>", tag, obs);
      end else begin
         e = sb.pop_front();
         assert (obs === e) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, e);
         end
      end
   endtask

   task automatic tick();
      @(posedge wrt_clk);
      #1;
   endtask

   task automatic expect_state(input int unsigned addr, input int unsigned ptr,
                               input int unsigned lvl, input int unsigned f,
                               input int unsigned af, input int unsigned ovf,
                               input int unsigned flips);
      push(addr); push(ptr); push(lvl); push(f); push(af); push(ovf); push(flips);
   endtask

   task automatic check_state();
      chk("wrt_addr",    32'(wrt_addr));
      chk("wrt_ptr",     32'(wrt_ptr));
      chk("wrt_level",   32'(wrt_level));
      chk("full",        32'(full));
      chk("almost_full", 32'(almost_full));
      chk("wrt_ovf",     32'(wrt_ovf));
      chk("ptr_flips",   32'(ones(prev_ptr ^ wrt_ptr)));
      prev_ptr = wrt_ptr;
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog expired before end of sequence");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned n;

      // Reset for two edges with a write requested
      wrt_rst  = 1'b1;
      wrt_en   = 1'b1;
      rd_ptr   = '0;
      prev_ptr = '0;
      tick();
      expect_state(0, 0, 0, 0, 0, 0, 0);
      tick();
      check_state();
      push(0);
      chk("accept_in_reset", 32'(wrt_accept));

      // Fill with the reader idle: 16 accepted, 17 and 18 rejected
      wrt_rst = 1'b0;
      for (int i = 1; i <= 18; i++) begin
         n = (i > 16) ? 16 : i;
         #1;
         push((i <= 16) ? 1 : 0);
         chk("accept_fill", 32'(wrt_accept));
         expect_state(n % 16, 32'(gray(5'(n))), n,
                      (n >= 16) ? 1 : 0, (n >= 14) ? 1 : 0,
                      (i >= 17) ? 1 : 0, (i <= 16) ? 1 : 0);
         tick();
         check_state();
      end
      push(32'h18);
      chk("ptr_when_full", 32'(wrt_ptr));

      // Release one slot: full drops after the third edge
      wrt_en = 1'b0;
      rd_ptr = 5'b00001;
      for (int k = 1; k <= 2; k++) begin
         expect_state(0, 32'h18, 16, 1, 1, 1, 0);
         tick();
         check_state();
      end
      expect_state(0, 32'h18, 15, 0, 1, 1, 0);
      tick();
      check_state();
      wrt_en = 1'b1;
      #1;
      push(1);
      chk("accept_on_release", 32'(wrt_accept));
      expect_state(1, 32'h19, 16, 1, 1, 1, 1);
      tick();
      check_state();
      expect_state(1, 32'h19, 16, 1, 1, 1, 0);
      tick();
      check_state();

      // Reset clears everything, then 7 writes and a reset mid-burst
      wrt_en  = 1'b0;
      rd_ptr  = '0;
      wrt_rst = 1'b1;
      expect_state(0, 0, 0, 0, 0, 0, 3);
      tick();
      check_state();
      wrt_rst = 1'b0;
      wrt_en  = 1'b1;
      for (int i = 1; i <= 7; i++) begin
         expect_state(i, 32'(gray(5'(i))), i, 0, 0, 0, 1);
         tick();
         check_state();
      end
      wrt_rst = 1'b1;
      #1;
      push(0);
      chk("accept_mid_reset", 32'(wrt_accept));
      expect_state(0, 0, 0, 0, 0, 0, 1);
      tick();
      check_state();

      // 40 writes with the reader tracking; level sits at sync latency
      wrt_rst = 1'b0;
      for (int i = 1; i <= 40; i++) begin
         rd_ptr = gray(5'((i - 1) % 32));
         expect_state(i % 16, 32'(gray(5'(i % 32))), (i < 3) ? i : 3,
                      0, 0, 0, 1);
         tick();
         check_state();
         if (i == 32) begin
            push(0);
            chk("ptr_after_wrap", 32'(wrt_ptr));
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/wrt_ptr_full_ctrl.md
WRT_PTR_FULL_CTRL -- requirements
Module: wrt_ptr_full_ctrl

Interface
REQ-001 SHALL have parameter ADDR_SIZE, default 4, meaning FIFO depth 2**ADDR_SIZE; legal range 2..12.
REQ-002 SHALL have parameter AFULL_THRESH, default 14, meaning fill level at or above which almost_full asserts; legal range 1..2**ADDR_SIZE.
REQ-003 SHALL have port wrt_clk, input, 1 bit, meaning the write-domain clock, rising edge only; this is the block's only clock.
REQ-004 SHALL have port wrt_rst, input, 1 bit, meaning reset; synchronous and active-high.
REQ-005 SHALL have port wrt_en, input, 1 bit, meaning a write is requested this cycle.
REQ-006 SHALL have port rd_ptr, input, ADDR_SIZE+1 bits, meaning the Gray-coded read pointer, asynchronous to wrt_clk.
REQ-007 SHALL have port wrt_ptr, output, ADDR_SIZE+1 bits, meaning the registered Gray-coded write pointer sent to the read domain.
REQ-008 SHALL have port wrt_addr, output, ADDR_SIZE bits, meaning the binary RAM write address.
REQ-009 SHALL have port wrt_accept, output, 1 bit, meaning a write is accepted this cycle (combinational).
REQ-010 SHALL have port full, output, 1 bit, meaning the FIFO is full (registered).
REQ-011 SHALL have port almost_full, output, 1 bit, meaning the fill level is at or above AFULL_THRESH (registered).
REQ-012 SHALL have port wrt_level, output, ADDR_SIZE+1 bits, meaning the conservative fill level (registered).
REQ-013 SHALL have port wrt_ovf, output, 1 bit, meaning a write was attempted while full; sticky.

Function
REQ-014 SHALL synchronise rd_ptr through two flops, rq1 then rq2, clocked by wrt_clk; no logic SHALL sit between rd_ptr and rq1.
REQ-015 SHALL hold wbin, an ADDR_SIZE+1-bit binary write counter; wrt_addr SHALL equal wbin[ADDR_SIZE-1:0].
REQ-016 SHALL drive wrt_accept = wrt_en AND NOT full.
REQ-017 SHALL compute wbin_next = wbin + wrt_accept, modulo 2**(ADDR_SIZE+1), so the counter wraps from all-ones to 0.
REQ-018 SHALL compute wgray_next = (wbin_next >> 1) XOR wbin_next, and register wbin_next and wgray_next on each edge.
REQ-019 SHALL register wgray_next directly into wrt_ptr, so that only one bit of wrt_ptr changes per accepted write.
REQ-020 SHALL register full <= (wgray_next == {~rq2[ADDR_SIZE:ADDR_SIZE-1], rq2[ADDR_SIZE-2:0]}).
- full therefore asserts on the same edge that commits the write filling the last slot.
REQ-021 SHALL compute rbin_sync as the Gray-to-binary conversion of rq2, as an XOR prefix from the MSB.
REQ-022 SHALL register wrt_level <= wbin_next - rbin_sync, modulo 2**(ADDR_SIZE+1); the value never exceeds 2**ADDR_SIZE.
REQ-023 SHALL register almost_full <= (level_next >= AFULL_THRESH), where level_next is the value being registered into wrt_level.
REQ-024 SHALL set wrt_ovf on any edge where wrt_en=1 and full=1; wrt_ovf SHALL clear only on reset.
REQ-025 SHALL leave wbin, wrt_ptr and the RAM untouched on a write attempted while full.
REQ-026 SHALL deassert full no earlier than the 3rd wrt_clk edge after rd_ptr changes: 2 synchroniser edges plus 1 flag edge; full and almost_full are therefore pessimistic only.
REQ-027 SHALL accept a write when wrt_en=1 in the same cycle full deasserts, because the decision uses the registered full value.

Reset
REQ-028 SHALL, on the wrt_clk edge where wrt_rst=1, clear rq1, rq2, wbin, wrt_ptr, wrt_level, full, almost_full and wrt_ovf to 0; reset SHALL take priority over wrt_en.
REQ-029 SHALL force wrt_accept to 0 while wrt_rst=1.
REQ-030 SHALL, when reset is asserted mid-burst, discard the pointer state, so the next accepted write goes to wrt_addr=0.

Verification (ADDR_SIZE=4, AFULL_THRESH=14)
REQ-031 SHALL check reset: wrt_rst=1 for 2 edges with wrt_en=1 -> all outputs 0 and wrt_accept=0.
REQ-032 SHALL check fill: rd_ptr=0, wrt_en=1 for 18 cycles ->
- almost_full=1 after the 14th accepted write;
- full=1 after the 16th, with wrt_ptr=5'b11000 and wrt_level=16;
- writes 17 and 18 are rejected and wrt_ovf=1.
REQ-033 SHALL check release: from full, rd_ptr set to 5'b00001 -> full=0 after exactly the 3rd edge and wrt_level=15; if wrt_en=1 on that cycle, the write is accepted and full=1 again.
REQ-034 SHALL check wrap: with rd_ptr tracking, write 40 words -> wbin passes 31 to 0, wrt_ptr goes 5'b10000 to 5'b00000, and there is no false full.
REQ-035 SHALL check Gray property: every accepted write changes exactly 1 bit of wrt_ptr, and a rejected write changes 0 bits.
REQ-036 SHALL check reset mid-burst: wrt_rst=1 after 7 writes -> wrt_addr=0, wrt_level=0, wrt_ovf=0 on the next edge.
